// File: rtl/mips_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, IR field
// positions and the control state encoding.
package mips_pkg;

  // Opcodes (oper_type field)
  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_AND     = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8;
  localparam logic [4:0] OP_NAND    = 5'd9;
  localparam logic [4:0] OP_NOR     = 5'd10;
  localparam logic [4:0] OP_NOT     = 5'd11;
  localparam logic [4:0] OP_JMP     = 5'd12;
  localparam logic [4:0] OP_HLT     = 5'd31;

  // IR field bit positions
  localparam int OPER_MSB  = 31;
  localparam int OPER_LSB  = 27;
  localparam int RDST_MSB  = 26;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int IMM_BIT   = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 11;
  localparam int ISRC_MSB  = 15;
  localparam int ISRC_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  // ALU-class opcodes occupy the contiguous range 0..OP_NOT
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Down-counter that stretches EXECUTE for multi-cycle ALU operations.
// done is high whenever the count has reached zero.
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority; decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: fetches instructions over a req/ack handshake
// and walks each through FETCH, DECODE, EXECUTE and WRITEBACK, driving the
// register-file addresses, ALU controls and write-back strobe.
module instr_sequencer
  import mips_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  output logic [4:0]      alu_op,
  output logic            alu_imm,
  output logic            alu_en,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              illegal_q, illegal_d;
  logic              cnt_load, cnt_dec, cnt_done;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [4:0]        op;

  assign op = ir_q[OPER_MSB:OPER_LSB];

  // MUL holds EXECUTE for MUL_LAT cycles; everything else for one
  assign cnt_load_val = (op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;

  lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst      (sys_rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Next-state, PC/IR update and per-state strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cnt_load = 1'b1;
        state_d  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_alu_op(op)) begin
          alu_en = 1'b1;
          if (cnt_done) state_d = ST_WRITEBACK;
          else          cnt_dec = 1'b1;
        end else if (op == OP_JMP) begin
          // Jump target replaces the already-incremented PC
          pc_d    = PC_W'(ir_q[ISRC_MSB:ISRC_LSB]);
          state_d = ST_FETCH;
        end else if (op == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        rf_we   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC, IR and sticky illegal flag
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign alu_op    = op;
  assign rf_waddr  = ir_q[RDST_MSB:RDST_LSB];
  assign rf_raddr1 = ir_q[RSRC1_MSB:RSRC1_LSB];
  assign alu_imm   = ir_q[IMM_BIT];
  assign rf_raddr2 = ir_q[RSRC2_MSB:RSRC2_LSB];
  assign halted    = (state_q == ST_HALT);
  assign illegal   = illegal_q;

endmodule
